// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks one pending functional-unit result per cycle,
// round-robin, and broadcasts it with the producer's tag and a registered Ack.
module cdb_arbiter #(
    parameter int                N_REQ    = 3,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] NO_VALUE = 16'hFFF0
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Flush,
    input  logic [N_REQ-1:0]          Req,
    input  logic [DATA_W*N_REQ-1:0]   Req_Data,
    output logic [N_REQ-1:0]          Ack,
    output logic                      Cdb_Valid,
    output logic [2:0]                Cdb_Tag,
    output logic [DATA_W-1:0]         Cdb_Data
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_INIT = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0]  last_grant_r;
    logic [N_REQ-1:0]  ack_r;
    logic              cdb_valid_r;
    logic [2:0]        cdb_tag_r;
    logic [DATA_W-1:0] cdb_data_r;

    logic [N_REQ-1:0]  eligible_s;
    logic              win_found_s;
    logic [PTR_W-1:0]  win_idx_s;
    logic [N_REQ-1:0]  ack_next_s;
    logic [DATA_W-1:0] data_next_s;

    // Returns {found, index} of the first eligible requester after 'last'.
    function automatic logic [PTR_W:0] pick_winner(
        input logic [N_REQ-1:0] elig,
        input logic [PTR_W-1:0] last
    );
        logic [PTR_W:0] res;
        int             cand;
        res = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(last) + off) % N_REQ;
            if (!res[PTR_W] && elig[PTR_W'(cand)]) begin
                res = {1'b1, PTR_W'(cand)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Winner selection; a requester acked this cycle is masked to avoid a double grant.
    always_comb begin
        eligible_s  = Req & ~ack_r;
        {win_found_s, win_idx_s} = pick_winner(eligible_s, last_grant_r);
        ack_next_s  = '0;
        data_next_s = NO_VALUE;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_found_s && (win_idx_s == PTR_W'(i))) begin
                ack_next_s[i] = 1'b1;
                data_next_s   = Req_Data[i*DATA_W +: DATA_W];
            end else begin
                ack_next_s[i] = 1'b0;
            end
        end
    end

    // Registered bus outputs and round-robin pointer; Flush behaves like a synchronous reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ack_r        <= '0;
            cdb_valid_r  <= 1'b0;
            cdb_tag_r    <= 3'd0;
            cdb_data_r   <= NO_VALUE;
            last_grant_r <= LAST_INIT;
        end else if (Flush) begin
            ack_r        <= '0;
            cdb_valid_r  <= 1'b0;
            cdb_tag_r    <= 3'd0;
            cdb_data_r   <= NO_VALUE;
            last_grant_r <= LAST_INIT;
        end else if (win_found_s) begin
            ack_r        <= ack_next_s;
            cdb_valid_r  <= 1'b1;
            cdb_tag_r    <= 3'(win_idx_s) + 3'd1;
            cdb_data_r   <= data_next_s;
            last_grant_r <= win_idx_s;
        end else begin
            ack_r        <= '0;
            cdb_valid_r  <= 1'b0;
            cdb_tag_r    <= 3'd0;
            cdb_data_r   <= NO_VALUE;
            last_grant_r <= last_grant_r;
        end
    end

    assign Ack       = ack_r;
    assign Cdb_Valid = cdb_valid_r;
    assign Cdb_Tag   = cdb_tag_r;
    assign Cdb_Data  = cdb_data_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural round-robin reference model.
module tb_cdb_arbiter;

    localparam int N = 3;
    localparam logic [15:0] NOV = 16'hFFF0;
    localparam logic [22:0] IDLE_V = {3'b000, 1'b0, 3'd0, 16'hFFF0};

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Flush = 1'b0;
    logic [2:0]  Req = 3'b000;
    logic [47:0] Req_Data = 48'd0;
    logic [2:0]  Ack;
    logic        Cdb_Valid;
    logic [2:0]  Cdb_Tag;
    logic [15:0] Cdb_Data;

    int errors = 0;
    int checks = 0;

    // reference model state
    int          m_ptr;
    int          m_prev;
    logic [2:0]  exp_ack;
    logic        exp_valid;
    logic [2:0]  exp_tag;
    logic [15:0] exp_data;

    cdb_arbiter #(.N_REQ(3), .DATA_W(16), .NO_VALUE(16'hFFF0)) dut (
        .Clock(Clock), .Reset(Reset), .Flush(Flush), .Req(Req), .Req_Data(Req_Data),
        .Ack(Ack), .Cdb_Valid(Cdb_Valid), .Cdb_Tag(Cdb_Tag), .Cdb_Data(Cdb_Data)
    );

    always #5 Clock = ~Clock;

    task automatic model_reset();
        m_ptr = N - 1; m_prev = -1;
        exp_ack = 3'b000; exp_valid = 1'b0; exp_tag = 3'd0; exp_data = NOV;
    endtask

    // Predicts the bus after the coming edge from the inputs currently driven.
    task automatic model_edge();
        int w;
        int c;
        w = -1;
        if (Flush) begin
            m_ptr = N - 1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (w < 0 && Req[c] && c != m_prev) w = c;
            end
            if (w >= 0) m_ptr = w;
        end
        m_prev = w;
        if (w >= 0) begin
            exp_ack = 3'(1 << w); exp_valid = 1'b1; exp_tag = 3'(w + 1);
            exp_data = Req_Data[w*16 +: 16];
        end else begin
            exp_ack = 3'b000; exp_valid = 1'b0; exp_tag = 3'd0; exp_data = NOV;
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic step();
        model_edge();
        tick();
    endtask

    task automatic flush_pulse();
        Flush = 1'b1; step(); Flush = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if ({Ack, Cdb_Valid, Cdb_Tag, Cdb_Data} !== IDLE_V) begin
            errors++; $display("FAIL reset_state: got %h want %h", {Ack, Cdb_Valid, Cdb_Tag, Cdb_Data}, IDLE_V);
        end
        Reset = 1'b0; model_reset();
        Req = 3'b001; Req_Data = {16'h000C, 16'h000B, 16'h000A};
        step(); Req = 3'b000;
        checks++;
        if (Cdb_Valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_grant: valid got %b want 1", Cdb_Valid);
        end
        #3 Reset = 1'b1;
        #1;
        checks++;
        if ({Ack, Cdb_Valid, Cdb_Tag, Cdb_Data} !== IDLE_V) begin
            errors++; $display("FAIL async_reset: got %h want %h", {Ack, Cdb_Valid, Cdb_Tag, Cdb_Data}, IDLE_V);
        end
        tick(); Reset = 1'b0; model_reset();
        Req = 3'b111; step();
        checks++;
        if (Cdb_Tag !== 3'd1 || Ack !== 3'b001) begin
            errors++; $display("FAIL post_reset_first: tag %0d ack %b want 1 001", Cdb_Tag, Ack);
        end
        Req = 3'b000; step();
    endtask

    task automatic test_single();
        Req = 3'b001; Req_Data = {16'h0000, 16'h0000, 16'h0012};
        step(); Req = 3'b000;
        checks++;
        if ({Ack, Cdb_Valid, Cdb_Tag, Cdb_Data} !== {3'b001, 1'b1, 3'd1, 16'h0012}) begin
            errors++; $display("FAIL single_grant: got %h want %h", {Ack, Cdb_Valid, Cdb_Tag, Cdb_Data}, {3'b001, 1'b1, 3'd1, 16'h0012});
        end
        step();
        checks++;
        if ({Ack, Cdb_Valid, Cdb_Tag, Cdb_Data} !== IDLE_V) begin
            errors++; $display("FAIL single_idle: got %h want %h", {Ack, Cdb_Valid, Cdb_Tag, Cdb_Data}, IDLE_V);
        end
    endtask

    task automatic test_contention();
        logic [2:0] want_ack;
        flush_pulse();
        Req = 3'b111; Req_Data = {16'h000C, 16'h000B, 16'h000A};
        for (int i = 0; i < 6; i++) begin
            step();
            want_ack = 3'(1 << (i % 3));
            checks++;
            if ({Ack, Cdb_Valid, Cdb_Tag, Cdb_Data} !== {want_ack, 1'b1, 3'((i % 3) + 1), 16'(10 + (i % 3))}) begin
                errors++; $display("FAIL contention[%0d]: got %h want %h", i, {Ack, Cdb_Valid, Cdb_Tag, Cdb_Data},
                                   {want_ack, 1'b1, 3'((i % 3) + 1), 16'(10 + (i % 3))});
            end
        end
        Req = 3'b000; step();
    endtask

    task automatic test_sole();
        Req = 3'b010; Req_Data = {16'h0000, 16'h0007, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (Cdb_Valid !== ((i % 2) == 0) || Cdb_Tag !== (((i % 2) == 0) ? 3'd2 : 3'd0)) begin
                errors++; $display("FAIL sole[%0d]: valid %b tag %0d want %b %0d", i, Cdb_Valid, Cdb_Tag,
                                   (i % 2) == 0, ((i % 2) == 0) ? 2 : 0);
            end
        end
        Req = 3'b000; step();
    endtask

    task automatic test_flush();
        flush_pulse();
        Req = 3'b001; Req_Data = {16'h0033, 16'h0022, 16'h0011};
        step();
        Req = 3'b110; Flush = 1'b1; step(); Flush = 1'b0;
        checks++;
        if (Cdb_Valid !== 1'b0 || Ack !== 3'b000) begin
            errors++; $display("FAIL flush_nogrant: valid %b ack %b want 0 000", Cdb_Valid, Ack);
        end
        step();
        checks++;
        if (Cdb_Tag !== 3'd2 || Cdb_Data !== 16'h0022) begin
            errors++; $display("FAIL flush_next: tag %0d data %h want 2 0022", Cdb_Tag, Cdb_Data);
        end
        Req = 3'b000; step();
    endtask

    task automatic test_rotation();
        logic [2:0] pat [3];
        logic [2:0] want [3];
        pat[0] = 3'b101; pat[1] = 3'b101; pat[2] = 3'b001;
        want[0] = 3'd1;  want[1] = 3'd3;  want[2] = 3'd1;
        flush_pulse();
        Req_Data = {16'h0303, 16'h0202, 16'h0101};
        for (int i = 0; i < 3; i++) begin
            Req = pat[i]; step();
            checks++;
            if (Cdb_Valid !== 1'b1 || Cdb_Tag !== want[i] || Cdb_Tag === 3'd0) begin
                errors++; $display("FAIL rotation[%0d]: valid %b tag %0d want 1 %0d", i, Cdb_Valid, Cdb_Tag, want[i]);
            end
        end
        Req = 3'b000; step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Req = 3'($urandom_range(0, 7));
            Req_Data = {16'($urandom), 16'($urandom), 16'($urandom)};
            Flush = ($urandom_range(0, 9) == 0);
            step();
            checks++;
            if ({Ack, Cdb_Valid, Cdb_Tag, Cdb_Data} !== {exp_ack, exp_valid, exp_tag, exp_data}) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", i, {Ack, Cdb_Valid, Cdb_Tag, Cdb_Data},
                                   {exp_ack, exp_valid, exp_tag, exp_data});
            end
            if (Cdb_Valid === 1'b1) begin
                checks++;
                if ($countones(Ack) != 1 || Cdb_Tag === 3'd0) begin
                    errors++; $display("FAIL random_onehot[%0d]: ack %b tag %0d", i, Ack, Cdb_Tag);
                end
            end
        end
        Flush = 1'b0; Req = 3'b000;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_sole();
        test_flush();
        test_rotation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
